// File: rtl/playback_arbiter.sv
// playback_arbiter: debounced mode select with a muted guard gap on every hand-over.
// Optional KEY_PREEMPT_EN: keyboard pre-empts the auto player without a guard gap.
module playback_arbiter #(
  parameter int CNT_W = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYC = CNT_W'(1_000_000),
  parameter logic [CNT_W-1:0] GUARD_CYC = CNT_W'(500_000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode_sw,
  input  logic [6:0] key,
  input  logic       spk_auto,
  input  logic       spk_key,
  input  logic       spk_learn,
  input  logic [7:0] led_auto,
  input  logic [7:0] led_learn,
  output logic       speaker,
  output logic [7:0] led,
  output logic [2:0] src_en,
  output logic [1:0] sel,
  output logic [1:0] msg_id,
  output logic       busy
);

  typedef enum logic {GRANT, MUTE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] GD_LAST = GUARD_CYC - CNT_W'(1);

  state_t state, state_nxt;

  logic [2:0] samp;
  logic [CNT_W-1:0] db_cnt, db_nxt;
  logic [CNT_W-1:0] gd_cnt, gd_nxt;
  logic [1:0] tgt, acc, acc_nxt;
  logic [1:0] pend, pend_nxt;
  logic fire;

  logic speaker_nxt, busy_nxt;
  logic [7:0] led_nxt;
  logic [2:0] src_nxt;
  logic [1:0] sel_nxt, msg_nxt;
  logic pre_hold, pre_nxt;

  always_comb begin
    unique case (1'b1)
      (mode_sw == 3'b011): tgt = 2'd1;
      (mode_sw == 3'b001): tgt = 2'd2;
      (mode_sw == 3'b111): tgt = 2'd3;
      default:             tgt = 2'd0;
    endcase
  end

  // fire is a one-cycle strobe on the edge the stable run reaches its length
  always_comb begin
    db_nxt = db_cnt;
    fire = 1'b0;
    if (mode_sw != samp) begin
      db_nxt = '0;
    end else if (db_cnt != DB_LAST) begin
      db_nxt = db_cnt + CNT_W'(1);
      fire = (db_nxt == DB_LAST);
    end
    acc_nxt = fire ? tgt : acc;
  end

`ifdef KEY_PREEMPT_EN
  logic [6:0] key_s1, key_s2;
  logic [CNT_W-1:0] kc;
  logic pre, key_any, key_rel;

  assign key_any = |key_s2;
  assign key_rel = !key_any && (kc == DB_LAST);
  assign pre_hold = (sel == 2'd1) && (key_any || (pre && !key_rel));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      key_s1 <= '0;
      key_s2 <= '0;
      kc <= '0;
      pre <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      pre <= pre_nxt;
      if (key_any)
        kc <= '0;
      else if (kc != DB_LAST)
        kc <= kc + CNT_W'(1);
    end
  end
`else
  logic unused_key;
  assign unused_key = ^key;
  assign pre_hold = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gd_nxt = gd_cnt;
    pend_nxt = pend;
    sel_nxt = sel;
    msg_nxt = msg_id;
    src_nxt = src_en;
    busy_nxt = busy;
    speaker_nxt = 1'b0;
    led_nxt = 8'h00;
    pre_nxt = 1'b0;
    unique case (state)
      GRANT: begin
        if (acc_nxt != sel) begin
          state_nxt = MUTE;
          gd_nxt = '0;
          pend_nxt = acc_nxt;
          src_nxt = 3'b000;
          busy_nxt = 1'b1;
        end else begin
          pre_nxt = pre_hold;
          unique case (sel)
            2'd1: begin
              speaker_nxt = pre_nxt ? spk_key : spk_auto;
              led_nxt = pre_nxt ? led : led_auto;
              src_nxt = pre_nxt ? 3'b010 : 3'b001;
            end
            2'd2: speaker_nxt = spk_key;
            2'd3: begin
              speaker_nxt = spk_learn;
              led_nxt = led_learn;
            end
            default: ;
          endcase
        end
      end
      MUTE: begin
        if (acc_nxt != pend) begin
          pend_nxt = acc_nxt;
          gd_nxt = '0;
        end else if (gd_cnt == GD_LAST) begin
          state_nxt = GRANT;
          sel_nxt = pend;
          msg_nxt = pend;
          busy_nxt = 1'b0;
          unique case (pend)
            2'd1: src_nxt = 3'b001;
            2'd2: src_nxt = 3'b010;
            2'd3: src_nxt = 3'b100;
            default: src_nxt = 3'b000;
          endcase
        end else begin
          gd_nxt = gd_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= GRANT;
      samp <= '0;
      db_cnt <= '0;
      gd_cnt <= '0;
      acc <= '0;
      pend <= '0;
      speaker <= 1'b0;
      led <= '0;
      src_en <= '0;
      sel <= '0;
      msg_id <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      samp <= mode_sw;
      db_cnt <= db_nxt;
      gd_cnt <= gd_nxt;
      acc <= acc_nxt;
      pend <= pend_nxt;
      speaker <= speaker_nxt;
      led <= led_nxt;
      src_en <= src_nxt;
      sel <= sel_nxt;
      msg_id <= msg_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_playback_arbiter.sv
// tb_playback_arbiter: vector table, hand-written hand-over sequences and
// randomized switching against a run-length / countdown reference model.
module tb_playback_arbiter;

  localparam int D = 4;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] mode_sw;
  logic [6:0] key;
  logic spk_auto, spk_key, spk_learn;
  logic [7:0] led_auto, led_learn;
  logic speaker;
  logic [7:0] led;
  logic [2:0] src_en;
  logic [1:0] sel, msg_id;
  logic busy;

  int errors = 0;
  int checks = 0;

  playback_arbiter #(
    .CNT_W(20),
    .DEBOUNCE_CYC(20'd4),
    .GUARD_CYC(20'd8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_sw(mode_sw),
    .key(key),
    .spk_auto(spk_auto),
    .spk_key(spk_key),
    .spk_learn(spk_learn),
    .led_auto(led_auto),
    .led_learn(led_learn),
    .speaker(speaker),
    .led(led),
    .src_en(src_en),
    .sel(sel),
    .msg_id(msg_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // reference model: switch run length, owner, pending and mute countdown
  logic [2:0] m_last;
  int m_run;
  logic [1:0] m_acc, m_sel, m_pend, m_msg;
  logic [2:0] m_src;
  logic m_mute, m_busy, m_spk;
  logic [7:0] m_led;
  int m_remain;

  function automatic logic [1:0] owner_of(input logic [2:0] sw);
    case (sw)
      3'b011: return 2'd1;
      3'b001: return 2'd2;
      3'b111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_last = 3'b000;
    m_run = 1;
    m_acc = 0;
    m_sel = 0;
    m_pend = 0;
    m_msg = 0;
    m_src = 0;
    m_mute = 0;
    m_busy = 0;
    m_spk = 0;
    m_led = 0;
    m_remain = 0;
  endtask

  task automatic model_edge();
    if (mode_sw == m_last) m_run++;
    else begin
      m_run = 1;
      m_last = mode_sw;
    end
    if (m_run == D) m_acc = owner_of(mode_sw);
    if (!m_mute) begin
      if (m_acc != m_sel) begin
        m_mute = 1;
        m_remain = G;
        m_pend = m_acc;
        m_src = 0;
        m_busy = 1;
        m_spk = 0;
        m_led = 0;
      end else begin
        m_spk = (m_sel == 1) ? spk_auto : (m_sel == 2) ? spk_key :
                (m_sel == 3) ? spk_learn : 1'b0;
        m_led = (m_sel == 1) ? led_auto : (m_sel == 3) ? led_learn : 8'h00;
      end
    end else begin
      m_spk = 0;
      m_led = 0;
      if (m_acc != m_pend) begin
        m_pend = m_acc;
        m_remain = G;
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          m_mute = 0;
          m_busy = 0;
          m_sel = m_pend;
          m_msg = m_pend;
          m_src = (m_pend == 0) ? 3'b000 : 3'(3'b001 << (m_pend - 1));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".speaker"}, speaker, m_spk);
    chk({tag, ".led"}, led, m_led);
    chk({tag, ".src_en"}, src_en, m_src);
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".msg_id"}, msg_id, m_msg);
    chk({tag, ".busy"}, busy, m_busy);
  endtask

  typedef struct {
    logic [2:0] sw;
    int hold;
    logic [1:0] sel;
    logic [2:0] src;
    logic [1:0] msg;
    logic busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int cnt, at;
    logic prev;

    rst_n = 1'b1;
    mode_sw = 3'b000;
    key = '0;
    spk_auto = 0;
    spk_key = 0;
    spk_learn = 0;
    led_auto = 0;
    led_learn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.speaker", speaker, 0);
    chk("rst.led", led, 0);
    chk("rst.src_en", src_en, 0);
    chk("rst.sel", sel, 0);
    chk("rst.msg_id", msg_id, 0);
    chk("rst.busy", busy, 0);
    rst_n = 1'b0;

    tbl[0] = '{3'b011, 12, 2'd1, 3'b001, 2'd1, 1'b0};
    tbl[1] = '{3'b001, 12, 2'd2, 3'b010, 2'd2, 1'b0};
    tbl[2] = '{3'b111, 12, 2'd3, 3'b100, 2'd3, 1'b0};
    tbl[3] = '{3'b100, 12, 2'd0, 3'b000, 2'd0, 1'b0};
    tbl[4] = '{3'b000, 12, 2'd0, 3'b000, 2'd0, 1'b0};
    tbl[5] = '{3'b011, 11, 2'd0, 3'b000, 2'd0, 1'b1};
    tbl[6] = '{3'b011, 1, 2'd1, 3'b001, 2'd1, 1'b0};
    tbl[7] = '{3'b110, 3, 2'd1, 3'b001, 2'd1, 1'b0};
    tbl[8] = '{3'b011, 12, 2'd1, 3'b001, 2'd1, 1'b0};
    foreach (tbl[i]) begin
      mode_sw = tbl[i].sw;
      repeat (tbl[i].hold) step();
      chk($sformatf("tbl%0d.sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d.src_en", i), src_en, tbl[i].src);
      chk($sformatf("tbl%0d.msg_id", i), msg_id, tbl[i].msg);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
    end

    // glitch of 3 cycles must not start a hand-over
    cnt = 0;
    mode_sw = 3'b001;
    repeat (3) begin
      step();
      if (busy) cnt++;
    end
    mode_sw = 3'b011;
    repeat (10) begin
      step();
      if (busy) cnt++;
    end
    chk("glitch.busy_cycles", cnt, 0);
    chk("glitch.sel", sel, 1);

    // keyboard against the auto player
    spk_key = 1'b1;
    spk_auto = 1'b0;
    led_auto = 8'h3C;
    step();
    key = 7'b0000100;
`ifdef KEY_PREEMPT_EN
    repeat (3) step();
    chk("pre.src_en", src_en, 3'b010);
    chk("pre.speaker", speaker, 1);
    chk("pre.sel", sel, 1);
    chk("pre.msg_id", msg_id, 1);
    led_auto = 8'hC3;
    step();
    chk("pre.led_hold", led, 8'h3C);
    key = '0;
    cnt = 0;
    while (src_en != 3'b001 && cnt < 12) begin
      step();
      cnt++;
    end
    chk("pre.release", src_en, 3'b001);
    step();
    chk("pre.spk_auto", speaker, 0);
`else
    repeat (6) begin
      prev = 1'($urandom);
      spk_auto = prev;
      step();
      chk("key_ignored.src_en", src_en, 3'b001);
      chk("key_ignored.speaker", speaker, prev);
    end
    key = '0;
`endif

    // first hand-over timing and speaker latency
    do_reset();
    mode_sw = 3'b011;
    cnt = 0;
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      prev = 1'($urandom);
      spk_auto = prev;
      step();
      if (busy) cnt++;
      if (sel == 2'd1 && at == 0) at = i;
      if (i > 13) chk("a.speaker_delay", speaker, prev);
    end
    chk("a.busy_cycles", cnt, G);
    chk("a.grant_cycle", at, D + G);
    chk("a.src_en", src_en, 3'b001);
    chk("a.msg_id", msg_id, 1);

    // switch 011->111, then 001 during mute cycle 5: guard restarts
    spk_auto = 0;
    spk_key = 0;
    spk_learn = 1;
    led_learn = 8'hFF;
    mode_sw = 3'b111;
    cnt = 0;
    while (!busy && cnt < 10) begin
      step();
      cnt++;
    end
    chk("c.enter_mute", busy, 1);
    at = 0;
    cnt = 1;
    repeat (4) begin
      step();
      if (speaker) at++;
      if (busy) cnt++;
    end
    mode_sw = 3'b001;
    repeat (20) begin
      step();
      if (speaker) at++;
      if (busy) cnt++;
    end
    chk("c.busy_cycles", cnt, 16);
    chk("c.learn_leak", at, 0);
    chk("c.sel", sel, 2);
    chk("c.src_en", src_en, 3'b010);
    chk("c.led", led, 0);

    // asynchronous reset in the middle of a hand-over
    do_reset();
    spk_learn = 1;
    led_learn = 8'hA5;
    mode_sw = 3'b111;
    repeat (13) step();
    chk("d.sel", sel, 3);
    chk("d.led", led, 8'hA5);
    chk("d.speaker", speaker, 1);
    mode_sw = 3'b001;
    cnt = 0;
    while (!busy && cnt < 10) begin
      step();
      cnt++;
    end
    repeat (3) step();
    chk("d.in_mute", busy, 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("d.rst_speaker", speaker, 0);
    chk("d.rst_led", led, 0);
    chk("d.rst_sel", sel, 0);
    chk("d.rst_msg_id", msg_id, 0);
    chk("d.rst_busy", busy, 0);
    chk("d.rst_src_en", src_en, 0);

    // randomized switching against the model
    mode_sw = 3'b000;
    do_reset();
    for (int s = 0; s < 250; s++) begin
      int h;
      case ($urandom_range(0, 5))
        0: mode_sw = 3'b000;
        1: mode_sw = 3'b011;
        2: mode_sw = 3'b001;
        3: mode_sw = 3'b111;
        4: mode_sw = 3'b100;
        default: mode_sw = 3'b110;
      endcase
      h = $urandom_range(1, 24);
      repeat (h) begin
        spk_auto = 1'($urandom);
        spk_key = 1'($urandom);
        spk_learn = 1'($urandom);
        led_auto = 8'($urandom);
        led_learn = 8'($urandom);
        step();
        cmp_model("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playback_arbiter.md
Name: playback_arbiter

Overview:
- Sequencer and arbiter for the piano's shared output resources: speaker, 8 LEDs and the display message selector.
- Three sources compete for these resources: the auto player, the free-play keyboard and the learning engine.
- Debounces the mode switches and grants exactly one source at a time.
- On every hand-over, inserts a muted guard interval so no click or stale LED pattern leaks between modes.
- Sits between the source generators and the top-level speaker/LED/seg_display pins; replaces the combinational mode selector.

Parameters:
- DEBOUNCE_CYC, 20'd1_000_000: consecutive stable cycles of mode_sw before a new mode is accepted (10 ms at 100 MHz).
- GUARD_CYC, 20'd500_000: mute cycles inserted between releasing one source and granting the next.
- CNT_W, 20: width of the debounce and guard counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- mode_sw  in  3  raw switches: 011 auto, 001 manual, 111 learning, other = idle
- key  in  7  raw note keys (used only with KEY_PREEMPT_EN)
- spk_auto, spk_key, spk_learn  in  1 each  source speaker waveforms
- led_auto, led_learn  in  8 each  source LED patterns
- speaker  out  1  registered arbitrated speaker
- led  out  8  registered arbitrated LEDs
- src_en  out  3  one-hot source enable {learn, key, auto}
- sel  out  2  current owner: 0 none, 1 auto, 2 keyboard, 3 learning
- msg_id  out  2  display message: 0 HELLO, 1 AUTO, 2 FREE, 3 LEARN
- busy  out  1  high while in MUTE (hand-over in progress)

Behaviour:
- Reset (async, rst_n=1) values:
  - speaker=0, led=0, src_en=000, sel=0, msg_id=0, busy=0
  - state=GRANT, accepted mode=idle, counters=0
- Debounce:
  - Sample mode_sw each cycle; counter clears whenever the sample differs from the previous sample.
  - When the counter reaches DEBOUNCE_CYC-1 with the sample unchanged, the sample is the candidate.
  - Candidate mapped to a target: 011→1, 001→2, 111→3, anything else→0.
- FSM states: GRANT, MUTE.
- GRANT:
  - Outputs follow the owner, one register stage (1-cycle latency):
    - sel 1: speaker=spk_auto, led=led_auto
    - sel 2: speaker=spk_key, led=0
    - sel 3: speaker=spk_learn, led=led_learn
    - sel 0: speaker=0, led=0
  - A debounced target different from sel → go to MUTE.
  - On the same edge: src_en=000, speaker=0, led=0, busy=1, guard counter=0, pending target latched.
- MUTE:
  - speaker=0, led=0, src_en=000.
  - Guard counter increments every cycle.
  - A new debounced target ≠ pending while in MUTE: latch the new pending target and restart the guard counter at 0.
  - Counter reaches GUARD_CYC-1 → GRANT.
  - On the same edge: sel=pending, src_en=one-hot of pending (000 for 0), msg_id=pending, busy=0.
  - First source sample appears on speaker one cycle later.
- Debounced target equal to sel in GRANT: no action; no mute.
- Debounced target returning to the current sel while in MUTE: the guard interval still completes, then the same owner is re-granted.
- Hand-over latency from stable switch edge to first granted sample: DEBOUNCE_CYC + GUARD_CYC + 1 cycles.
- Counters saturate and never wrap; their width must hold the larger parameter.
- Reset mid-MUTE: immediately returns to the reset values; any pending target is discarded.

Optional Feature:
- Macro: KEY_PREEMPT_EN.
- Defined:
  - In GRANT with sel=1, any key bit high (synchronised through 2 flops) pre-empts the auto player.
  - src_en becomes 010, speaker follows spk_key, led holds the last led_auto value, sel stays 1, msg_id stays 1.
  - When all keys have been low for DEBOUNCE_CYC cycles, src_en returns to 001 and speaker follows spk_auto.
  - No guard interval is applied in either direction.
  - Pre-emption is cancelled immediately on entry to MUTE.
- Undefined: key is ignored entirely; there is no key-driven change of src_en.

Test Plan:
Run all scenarios with DEBOUNCE_CYC=4, GUARD_CYC=8.
- Reset, then mode_sw=011 held → after 4+8 cycles: sel=1, src_en=001, msg_id=1; speaker equals spk_auto delayed 1 cycle; busy high for exactly 8 cycles.
- mode_sw glitches 001 for 3 cycles, then back to 011 while sel=1 → no MUTE entered; sel stays 1; busy never asserts.
- While sel=1, switch to 111 and hold; at MUTE cycle 5 switch to 001 and hold → guard restarts after the 001 debounce; final sel=2, src_en=010, led=0; spk_learn never reaches speaker.
- sel=3 with led_learn=8'hA5; assert rst_n at MUTE cycle 3 → speaker=0, led=0, sel=0, msg_id=0, busy=0 asynchronously, before the next clk edge.
- mode_sw=3'b100 from sel=2 → after 4+8 cycles: sel=0, src_en=000, msg_id=0; speaker stays 0.
- KEY_PREEMPT_EN defined, sel=1: key=7'b0000100 → 3 cycles later src_en=010 and speaker follows spk_key; key=0 for 4 cycles → src_en=001.
